// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, instruction memory and fetch_phase.
// The master side is the sequencer; the slave side is its environment.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
) ();
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              stall;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_data;
    logic [7:0]        inst;
    logic [ADDR_W-1:0] pc;
    logic              inst_valid;
    logic              flush_out;

    modport master (
        input  redirect, redirect_pc, stall, imem_data,
        output imem_en, imem_addr, inst, pc, inst_valid, flush_out
    );

    modport slave (
        output redirect, redirect_pc, stall, imem_data,
        input  imem_en, imem_addr, inst, pc, inst_valid, flush_out
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Byte-stream fetch sequencer: issues imem reads against a credit limit,
// tracks the fixed-latency returns, buffers them in a small FIFO and hands
// one {inst, pc} per cycle to fetch_phase. Redirects restart the stream and
// raise a registered flush pulse.
module fetch_sequencer #(
    parameter int              ADDR_W       = 32,
    parameter int              LOAD_LATENCY = 1,
    parameter int              FIFO_DEPTH   = LOAD_LATENCY + 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic             clk,
    input  logic             rst,
    fetch_sequencer_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + LOAD_LATENCY + 1);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_flush;

    // Returns in flight: valid bits are control, addresses are plain data.
    logic [LOAD_LATENCY-1:0] r_pipe_vld;
    logic [ADDR_W-1:0]       r_pipe_addr [LOAD_LATENCY];

    // Output buffer.
    logic [7:0]        r_fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic [CNT_W-1:0]  w_inflight;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // Count outstanding reads so the credit check covers bytes not yet landed.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LOAD_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_pipe_vld[i]);
        end
    end

    // Next state plus issue/accept decisions; redirect wins from any state.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN: begin
                w_issue = ((r_count + w_inflight) < CNT_W'(FIFO_DEPTH));
                w_valid = (r_count != '0);
            end
            S_FLUSH: w_state_nxt = S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
        if (bus.redirect) w_state_nxt = S_FLUSH;
    end

    assign w_pop  = w_valid & ~bus.stall;
    assign w_push = r_pipe_vld[LOAD_LATENCY-1];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_BOOT;
        else     r_state <= w_state_nxt;
    end

    // Control state: fetch pointer, in-flight valids, FIFO pointers, flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_pipe_vld <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_flush    <= 1'b0;
        end else begin
            r_flush <= bus.redirect;
            if (bus.redirect) begin
                // Stale returns are dropped by clearing their valids.
                r_fetch_pc <= bus.redirect_pc;
                r_pipe_vld <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                r_pipe_vld[0] <= w_issue;
                for (int i = 1; i < LOAD_LATENCY; i++) begin
                    r_pipe_vld[i] <= r_pipe_vld[i-1];
                end
                if (w_push) r_wptr <= ptr_inc(r_wptr);
                if (w_pop)  r_rptr <= ptr_inc(r_rptr);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Data path: request addresses ride the pipe; returns land at the tail.
    always_ff @(posedge clk) begin
        r_pipe_addr[0] <= r_fetch_pc;
        for (int i = 1; i < LOAD_LATENCY; i++) begin
            r_pipe_addr[i] <= r_pipe_addr[i-1];
        end
        if (w_push) begin
            r_fifo_data[r_wptr] <= bus.imem_data;
            r_fifo_addr[r_wptr] <= r_pipe_addr[LOAD_LATENCY-1];
        end
    end

    assign bus.imem_en    = w_issue;
    assign bus.imem_addr  = r_fetch_pc;
    assign bus.inst_valid = w_valid;
    assign bus.inst       = w_valid ? r_fifo_data[r_rptr] : 8'h00;
    assign bus.pc         = w_valid ? r_fifo_addr[r_rptr] : '0;
    assign bus.flush_out  = r_flush;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && !bus.redirect && (r_count == CNT_W'(FIFO_DEPTH))));
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (L=1/depth 3 and L=3/depth 5)
// share one stimulus. Directed vector table, throughput sequence and a
// randomized run checked against an in-order stream model.
module tb_fetch_sequencer;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          stall;
    bit            chk_on;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_sequencer_if #(.ADDR_W(AW)) ifa ();
    fetch_sequencer_if #(.ADDR_W(AW)) ifb ();

    assign ifa.redirect    = redirect;
    assign ifa.redirect_pc = redirect_pc;
    assign ifa.stall       = stall;
    assign ifb.redirect    = redirect;
    assign ifb.redirect_pc = redirect_pc;
    assign ifb.stall       = stall;

    fetch_sequencer #(.ADDR_W(AW), .LOAD_LATENCY(1), .FIFO_DEPTH(3), .RESET_PC('0))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    fetch_sequencer #(.ADDR_W(AW), .LOAD_LATENCY(3), .FIFO_DEPTH(5), .RESET_PC('0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

    // Instruction memories: byte at address A is A[7:0]; garbage when not read.
    logic [7:0] mem_a;
    logic [7:0] mem_b [3];
    always @(posedge clk) begin
        mem_a    <= ifa.imem_en ? ifa.imem_addr[7:0] : 8'($urandom);
        mem_b[0] <= ifb.imem_en ? ifb.imem_addr[7:0] : 8'($urandom);
        mem_b[1] <= mem_b[0];
        mem_b[2] <= mem_b[1];
    end
    assign ifa.imem_data = mem_a;
    assign ifb.imem_data = mem_b[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream model: every byte shown is the next address of the current
    // stream, flush follows a redirect by one cycle, and the stream never
    // goes quiet for long outside of restarts.
    logic [AW-1:0] exp_pc [2];
    bit            exp_flush = 1'b0;
    int            idle [2];
    initial begin
        exp_pc[0] = '0; exp_pc[1] = '0;
        idle[0] = 0; idle[1] = 0;
    end

    always @(negedge clk) begin
        logic          v [2];
        logic [AW-1:0] p [2];
        logic [7:0]    d [2];
        logic          f [2];
        v[0] = ifa.inst_valid; p[0] = ifa.pc; d[0] = ifa.inst; f[0] = ifa.flush_out;
        v[1] = ifb.inst_valid; p[1] = ifb.pc; d[1] = ifb.inst; f[1] = ifb.flush_out;
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("m%0d_flush", k), 64'(f[k]), 64'(exp_flush));
                if (exp_flush) check($sformatf("m%0d_valid_in_flush", k), 64'(v[k]), 64'd0);
                if (v[k] === 1'b1) begin
                    check($sformatf("m%0d_pc", k), 64'(p[k]), 64'(exp_pc[k]));
                    check($sformatf("m%0d_inst", k), 64'(d[k]), 64'(exp_pc[k][7:0]));
                    idle[k] = 0;
                end else begin
                    idle[k]++;
                    if (idle[k] > 12) begin
                        check($sformatf("m%0d_stream_stuck", k), 64'(v[k]), 64'd1);
                        idle[k] = 0;
                    end
                end
            end
        end
        if (rst) begin
            exp_pc[0] = '0; exp_pc[1] = '0; exp_flush = 1'b0;
            idle[0] = 0; idle[1] = 0;
        end else if (redirect) begin
            exp_pc[0] = redirect_pc; exp_pc[1] = redirect_pc; exp_flush = 1'b1;
            idle[0] = 0; idle[1] = 0;
        end else begin
            exp_flush = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (v[k] === 1'b1 && !stall) exp_pc[k] = exp_pc[k] + 1;
            end
        end
    end

    typedef struct {
        bit            rst;
        bit            rd;
        logic [AW-1:0] rpc;
        bit            st;
        bit            en;
        logic [AW-1:0] addr;
        bit            v;
        logic [AW-1:0] pc;
        bit            fl;
    } vec_t;

    function automatic vec_t mk(bit r, bit rd, logic [AW-1:0] rpc, bit st,
                                bit en, logic [AW-1:0] addr, bit v,
                                logic [AW-1:0] pc, bit fl);
        vec_t t;
        t.rst = r; t.rd = rd; t.rpc = rpc; t.st = st;
        t.en = en; t.addr = addr; t.v = v; t.pc = pc; t.fl = fl;
        return t;
    endfunction

    initial begin
        vec_t tbl [$];
        int   first_a, first_b, cnt_a, cnt_b;

        // Instance A (L=1, depth 3): one row per cycle, outputs of that cycle.
        tbl.push_back(mk(1,0,0,0,        0,0,0,0,0));              // reset values
        tbl.push_back(mk(0,0,0,0,        0,0,0,0,0));              // BOOT
        tbl.push_back(mk(0,0,0,0,        1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,        1,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,        1,2,1,0,0));              // first byte
        tbl.push_back(mk(0,0,0,0,        1,3,1,1,0));
        tbl.push_back(mk(0,0,0,1,        1,4,1,2,0));              // stall begins
        tbl.push_back(mk(0,0,0,1,        0,5,1,2,0));
        tbl.push_back(mk(0,0,0,1,        0,5,1,2,0));
        tbl.push_back(mk(0,0,0,1,        0,5,1,2,0));
        tbl.push_back(mk(0,0,0,1,        0,5,1,2,0));
        tbl.push_back(mk(0,0,0,0,        0,5,1,2,0));              // released
        tbl.push_back(mk(0,0,0,0,        1,5,1,3,0));
        tbl.push_back(mk(0,0,0,0,        1,6,1,4,0));
        tbl.push_back(mk(0,0,0,0,        1,7,1,5,0));
        tbl.push_back(mk(0,1,32'h100,0,  1,8,1,6,0));              // redirect
        tbl.push_back(mk(0,0,0,0,        0,32'h100,0,0,1));        // FLUSH
        tbl.push_back(mk(0,0,0,0,        1,32'h100,0,0,0));
        tbl.push_back(mk(0,0,0,0,        1,32'h101,0,0,0));
        tbl.push_back(mk(0,0,0,0,        1,32'h102,1,32'h100,0));
        tbl.push_back(mk(0,1,32'h40,0,   1,32'h103,1,32'h101,0));  // back-to-back
        tbl.push_back(mk(0,1,32'h80,0,   0,32'h40,0,0,1));
        tbl.push_back(mk(0,0,0,0,        0,32'h80,0,0,1));
        tbl.push_back(mk(0,0,0,0,        1,32'h80,0,0,0));
        tbl.push_back(mk(0,0,0,0,        1,32'h81,0,0,0));
        tbl.push_back(mk(0,0,0,0,        1,32'h82,1,32'h80,0));
        tbl.push_back(mk(0,1,32'hFFFF_FFFE,0, 1,32'h83,1,32'h81,0));
        tbl.push_back(mk(0,0,0,0,        0,32'hFFFF_FFFE,0,0,1));
        tbl.push_back(mk(0,0,0,0,        1,32'hFFFF_FFFE,0,0,0));
        tbl.push_back(mk(0,0,0,0,        1,32'hFFFF_FFFF,0,0,0));
        tbl.push_back(mk(0,0,0,0,        1,0,1,32'hFFFF_FFFE,0));  // address wraps
        tbl.push_back(mk(0,0,0,0,        1,1,1,32'hFFFF_FFFF,0));
        tbl.push_back(mk(1,0,0,0,        1,2,1,0,0));              // reset mid-stream
        tbl.push_back(mk(0,0,0,0,        0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,        1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,        1,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,        1,2,1,0,0));
        tbl.push_back(mk(0,0,0,0,        1,3,1,1,0));

        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0; chk_on = 1'b0;
        repeat (2) tick();
        chk_on = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; redirect = tbl[i].rd;
            redirect_pc = tbl[i].rpc; stall = tbl[i].st;
            #1;
            check($sformatf("v%0d_imem_en", i),   64'(ifa.imem_en),    64'(tbl[i].en));
            check($sformatf("v%0d_imem_addr", i), 64'(ifa.imem_addr),  64'(tbl[i].addr));
            check($sformatf("v%0d_inst_valid", i),64'(ifa.inst_valid), 64'(tbl[i].v));
            check($sformatf("v%0d_flush_out", i), 64'(ifa.flush_out),  64'(tbl[i].fl));
            check($sformatf("v%0d_inst", i),      64'(ifa.inst),
                  tbl[i].v ? 64'(tbl[i].pc[7:0]) : 64'd0);
            if (tbl[i].v) check($sformatf("v%0d_pc", i), 64'(ifa.pc), 64'(tbl[i].pc));
            tick();
        end

        // Fresh start with no stall: first-byte latency and sustained rate.
        redirect = 1'b0; stall = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        first_a = -1; first_b = -1; cnt_a = 0; cnt_b = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (ifa.inst_valid && first_a < 0) first_a = cyc;
            if (ifb.inst_valid && first_b < 0) first_b = cyc;
            if (first_a >= 0 && cyc < first_a + 20 && ifa.inst_valid) cnt_a++;
            if (first_b >= 0 && cyc < first_b + 20 && ifb.inst_valid) cnt_b++;
            tick();
        end
        check("latency_L1", 64'(first_a), 64'd3);
        check("latency_L3", 64'(first_b), 64'd5);
        check("rate_L1_20cyc", 64'(cnt_a), 64'd20);
        check("rate_L3_20cyc", 64'(cnt_b), 64'd20);

        // Randomized stall / redirect / reset traffic.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int stall_pct;
            stall_pct = ((cyc / 500) % 2 == 0) ? 30 : 75;
            stall = ($urandom_range(99) < stall_pct);
            rst   = ($urandom_range(999) < 3);
            if ($urandom_range(99) < 3) begin
                redirect = 1'b1;
                redirect_pc = ($urandom_range(1) == 0) ? AW'($urandom)
                                                       : 32'hFFFF_FFF8 + AW'($urandom_range(7));
            end else if (redirect && $urandom_range(3) == 0) begin
                redirect = 1'b1;   // occasionally hold with the same target
            end else begin
                redirect = 1'b0;
            end
            tick();
        end
        rst = 1'b0; redirect = 1'b0; stall = 1'b0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
